// File: rtl/br_flow_serializer_reg.sv
// br_flow_serializer_reg
//
// Splits each wide push flit into SR = PushWidth/PopWidth narrow pop flits.
// One push flit is held at a time in a holding register; its slices are
// presented on the pop side one per accepted pop handshake. A packet's last
// push flit may drop trailing slices via push_last_dont_care_count.
//
// Optional feature macro: BR_FLOW_SERIALIZER_REG_PKT_COUNT_EN
//   When defined, adds output pop_packet_count[15:0]: a saturating count of
//   pop handshakes carrying pop_last=1, cleared by rst.
//
// Ports
//   clk                        clock, all state updates on posedge
//   rst                        synchronous active-high reset
//   push_ready / push_valid    push handshake
//   push_data [PushWidth]      wide flit
//   push_last                  last flit of packet
//   push_last_dont_care_count  trailing slices to drop (0 when !push_last)
//   push_metadata              sideband, replicated on every pop slice
//   pop_ready / pop_valid      pop handshake
//   pop_data [PopWidth]        current slice
//   pop_last                   final slice of a push_last flit
//   pop_metadata               captured sideband
//   pop_packet_count [16]      (macro only) saturating packet counter
module br_flow_serializer_reg #(
    parameter int PushWidth                     = 2,
    parameter int PopWidth                      = 1,
    parameter int MetadataWidth                 = 1,
    parameter int SerializeMostSignificantFirst = 0,
    parameter int RegisterPushReady             = 0,
    localparam int SR  = PushWidth / PopWidth,
    localparam int IdW = (SR > 1) ? $clog2(SR) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     push_ready,
    input  logic                     push_valid,
    input  logic [PushWidth-1:0]     push_data,
    input  logic                     push_last,
    input  logic [IdW-1:0]           push_last_dont_care_count,
    input  logic [MetadataWidth-1:0] push_metadata,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [PopWidth-1:0]      pop_data,
    output logic                     pop_last,
    output logic [MetadataWidth-1:0] pop_metadata
`ifdef BR_FLOW_SERIALIZER_REG_PKT_COUNT_EN
    ,
    output logic [15:0]              pop_packet_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t state, state_next;
    logic [IdW-1:0] flit_id, flit_id_next;

    // Holding register: data-path only, no reset needed because every
    // output derived from it is qualified by state==BUSY.
    logic [PushWidth-1:0]     held_data;
    logic                     held_last;
    logic [IdW-1:0]           held_dc;
    logic [MetadataWidth-1:0] held_meta;

    logic                     push_hs;
    logic                     pop_hs;
    logic                     final_slice;
    logic [IdW-1:0]           slice_sel;
    logic [SR-1:0][PopWidth-1:0] slices;

    assign push_hs = push_valid && push_ready;
    assign pop_hs  = pop_valid && pop_ready;

    generate
        if (SR == 1) begin : g_single
            // Degenerate case: a plain 1-deep pipeline register.
            logic unused_dc;
            assign unused_dc   = ^held_dc;
            assign final_slice = 1'b1;
            assign slice_sel   = '0;
        end else begin : g_multi
            // Sum wraps at IdW bits; legal dont-care counts keep it in range.
            logic [IdW-1:0] id_sum;
            assign id_sum      = flit_id + held_dc;
            assign final_slice = (id_sum == IdW'(SR - 1));
            if (SerializeMostSignificantFirst != 0) begin : g_msf
                assign slice_sel = IdW'(SR - 1) - flit_id;
            end else begin : g_lsf
                assign slice_sel = flit_id;
            end
        end
    endgenerate

    assign slices       = held_data;
    assign pop_valid    = (state == BUSY);
    assign pop_data     = slices[slice_sel];
    assign pop_last     = pop_valid && held_last && final_slice;
    assign pop_metadata = held_meta;

    // Registered-ready variant only accepts when empty, trading one idle pop
    // cycle per flit for no pop_ready -> push_ready combinational path.
    generate
        if (RegisterPushReady != 0) begin : g_reg_ready
            assign push_ready = (state == EMPTY);
        end else begin : g_comb_ready
            assign push_ready = (state == EMPTY) || (pop_ready && final_slice);
        end
    endgenerate

    always_comb begin
        state_next   = state;
        flit_id_next = flit_id;
        case (state)
            EMPTY: begin
                if (push_hs) state_next = BUSY;
            end
            BUSY: begin
                // A push in the same cycle as the final pop reloads in place.
                if (pop_hs && final_slice) state_next = push_hs ? BUSY : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
        if (pop_hs) flit_id_next = final_slice ? '0 : flit_id + IdW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            flit_id <= '0;
        end else begin
            state   <= state_next;
            flit_id <= flit_id_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_hs) begin
            held_data <= push_data;
            held_last <= push_last;
            held_dc   <= push_last_dont_care_count;
            held_meta <= push_metadata;
        end
    end

`ifdef BR_FLOW_SERIALIZER_REG_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_packet_count <= '0;
        end else if (pop_hs && pop_last && (pop_packet_count != 16'hFFFF)) begin
            pop_packet_count <= pop_packet_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/br_flow_serializer_reg.md
BR_FLOW_SERIALIZER_REG -- requirements
Module: br_flow_serializer_reg

Interface
REQ-001 SHALL have parameter PushWidth, default 2, meaning push flit width; must be a positive multiple of PopWidth.
REQ-002 SHALL have parameter PopWidth, default 1, meaning pop flit width; must be at least 1.
REQ-003 SHALL have parameter MetadataWidth, default 1, meaning sideband width; must be at least 1.
REQ-004 SHALL have parameter SerializeMostSignificantFirst, default 0, meaning 1 sends the MS slice first and 0 sends the LS slice first.
REQ-005 SHALL have parameter RegisterPushReady, default 0, meaning 1 removes the pop_ready-to-push_ready combinational path.
REQ-006 SHALL derive localparams SR = PushWidth/PopWidth and IdW = (SR>1 ? $clog2(SR) : 1).
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock. One clock; all state posedge-triggered.
- rst  in  1  reset. Synchronous, active-high.
- push_ready  out  1  push handshake ready.
- push_valid  in  1  push handshake valid.
- push_data  in  PushWidth  wide flit.
- push_last  in  1  last flit of packet.
- push_last_dont_care_count  in  IdW  tail slices to drop; must be < SR, and 0 when push_last=0.
- push_metadata  in  MetadataWidth  sideband, replicated on each pop flit.
- pop_ready  in  1  pop handshake ready.
- pop_valid  out  1  pop handshake valid.
- pop_data  out  PopWidth  current slice.
- pop_last  out  1  final slice of a push_last flit.
- pop_metadata  out  MetadataWidth  captured metadata.

Function
REQ-008 SHALL capture push_data, push_last, push_last_dont_care_count and push_metadata into an internal holding register on push_valid && push_ready; push inputs need not stay stable after the handshake.
REQ-009 SHALL implement a 2-state FSM: EMPTY (holding register invalid) and BUSY (holding register valid); pop_valid = (state==BUSY).
REQ-010 SHALL have a push-to-first-pop latency of exactly 1 cycle: pop_valid rises on the cycle after the push handshake.
REQ-011 SHALL drive pop_data from the holding register via a binary mux; slice = SR-1-flit_id when SerializeMostSignificantFirst=1, else flit_id.
REQ-012 SHALL keep an IdW-bit flit_id counter that increments on each pop handshake, clearing to 0 when the final slice is accepted.
REQ-013 SHALL define final = (flit_id + held_dont_care_count == SR-1), computed at IdW width; pop_last = held_last && final.
REQ-014 SHALL make pop_last=0 on every slice when held_last=0, and SHALL emit SR - held_dont_care_count slices when held_last=1.
REQ-015 With RegisterPushReady=0, SHALL assert push_ready = (state==EMPTY) || (pop_ready && final), sustaining 1 pop flit per cycle across back-to-back push flits.
REQ-016 With RegisterPushReady=1, SHALL assert push_ready = (state==EMPTY), inserting one idle pop cycle between consecutive push flits.
REQ-017 Transitions: EMPTY->BUSY on push handshake; BUSY->EMPTY on final pop handshake with no push handshake; BUSY->BUSY with reload when the final pop handshake and a push handshake occur in the same cycle.
REQ-018 SHALL hold pop_valid, pop_data, pop_last and pop_metadata stable while pop_valid && !pop_ready.
REQ-019 When SR==1, SHALL behave as a 1-deep pipeline register (final always 1) and SHALL leave push_last_dont_care_count unused.

Reset
REQ-020 On rst=1, SHALL set state=EMPTY and flit_id=0, with pop_valid=0, pop_last=0, and push_ready=1 in the cycle after reset.
REQ-021 SHALL discard a partially serialized flit when rst is asserted mid-packet; after reset release, serialization SHALL begin at slice 0 of the next push flit.
REQ-022 Holding-register data and metadata SHALL NOT require reset.

Configuration
REQ-023 When BR_FLOW_SERIALIZER_REG_PKT_COUNT_EN is defined, SHALL add output pop_packet_count [15:0], which increments on each pop handshake with pop_last=1, saturates at 16'hFFFF, and resets to 0.
REQ-024 When BR_FLOW_SERIALIZER_REG_PKT_COUNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 PushWidth=32, PopWidth=8, MSFirst=1, push 32'hBAADF00D with last=0 and pop_ready=1 -> pop_data BA, AD, F0, 0D on cycles 1-4, pop_last=0 throughout.
REQ-026 MSFirst=0: push 32'h01234567 (last=0), then 32'hXXADF00D (last=1, dc=1) -> pops 67,45,23,01,0D,F0,AD with no gaps; pop_last=1 only on AD.
REQ-027 RegisterPushReady=1, two back-to-back push flits -> 8 slices over 9 cycles, with exactly one pop_valid=0 cycle between the flits.
REQ-028 Hold pop_ready=0 for 3 cycles at slice 1 -> pop outputs stay stable, push_ready=0, and the sequence resumes at slice 1.
REQ-029 Assert rst after 2 slices -> pop_valid=0 the next cycle; a new flit 32'h11223344 (MSFirst=1) pops 11 first.
REQ-030 With the macro defined, 70000 single-flit packets (last=1, dc=3) -> pop_packet_count=16'hFFFF.
